// File: rtl/spi_mem_loader.sv
// spi_mem_loader: bit-serial host frames (start, 24b addr, WE, 16b data) turned into memory bus cycles.
// Optional SPI_LOADER_READ_EN adds bus reads with the 16 read bits shifted back out on o_spi_miso.
module spi_mem_loader (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_enable,
    input  logic        i_spi_clk,
    input  logic        i_spi_mosi,
    output logic        o_spi_miso,
    output logic        o_req,
    output logic        o_we,
    output logic [23:0] o_addr,
    output logic [15:0] o_data,
    input  logic [15:0] i_data,
    input  logic        i_ack,
    input  logic        i_err,
    output logic        o_busy,
    output logic        o_err_sticky
);
    typedef enum logic [2:0] {IDLE, ADDR, WEBIT, DATA, BUS, DONE, RDOUT} state_t;
    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  sck_q, sck_d;
    logic [1:0]  mosi_q, mosi_d;
    logic [23:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        we_q, we_d, req_q, req_d, err_q, err_d;
    logic        rise, bit_in;
`ifdef SPI_LOADER_READ_EN
    logic [15:0] rdata_q, rdata_d;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sck_q   <= 3'b111;
            mosi_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            req_q   <= 1'b0;
            err_q   <= 1'b0;
`ifdef SPI_LOADER_READ_EN
            rdata_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            req_q   <= req_d;
            err_q   <= err_d;
`ifdef SPI_LOADER_READ_EN
            rdata_q <= rdata_d;
`endif
        end
    end

    always_comb begin
        sck_d   = {sck_q[1:0], i_spi_clk};
        mosi_d  = {mosi_q[0], i_spi_mosi};
        // mosi_q[1] has the same synchroniser age as sck_q[1], so it is the bit under the edge
        rise    = sck_q[1] & ~sck_q[2];
        bit_in  = mosi_q[1];
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = we_q;
        req_d   = req_q;
        err_d   = err_q;
`ifdef SPI_LOADER_READ_EN
        rdata_d = rdata_q;
`endif
        case (state_q)
            IDLE: if (rise && !bit_in) begin
                state_d = ADDR;
                cnt_d   = '0;
            end
            ADDR: if (rise) begin
                addr_d  = {bit_in, addr_q[23:1]};
                cnt_d   = (cnt_q == 5'd23) ? 5'd0 : cnt_q + 5'd1;
                state_d = (cnt_q == 5'd23) ? WEBIT : ADDR;
            end
            WEBIT: if (rise) begin
                we_d = bit_in;
`ifdef SPI_LOADER_READ_EN
                state_d = bit_in ? DATA : BUS;
                req_d   = !bit_in;
`else
                state_d = bit_in ? DATA : DONE;
`endif
            end
            DATA: if (rise) begin
                data_d  = {bit_in, data_q[15:1]};
                cnt_d   = (cnt_q == 5'd15) ? 5'd0 : cnt_q + 5'd1;
                state_d = (cnt_q == 5'd15) ? BUS : DATA;
                req_d   = (cnt_q == 5'd15);
            end
            BUS: if (i_ack || i_err) begin
                req_d   = 1'b0;
                state_d = DONE;
                err_d   = err_q | i_err;
`ifdef SPI_LOADER_READ_EN
                rdata_d = (i_ack && !i_err && !we_q) ? i_data : rdata_q;
`endif
            end
            DONE: if (rise) begin
`ifdef SPI_LOADER_READ_EN
                state_d = we_q ? IDLE : RDOUT;
                cnt_d   = '0;
`else
                state_d = IDLE;
`endif
            end
`ifdef SPI_LOADER_READ_EN
            RDOUT: if (rise) begin
                state_d = (cnt_q == 5'd15) ? IDLE : RDOUT;
                cnt_d   = cnt_q + 5'd1;
                rdata_d = {1'b0, rdata_q[15:1]};
            end
`endif
            default: state_d = IDLE;
        endcase
        if (!i_enable) begin
            state_d = IDLE;
            req_d   = 1'b0;
        end
    end

`ifdef SPI_LOADER_READ_EN
    assign o_spi_miso = (state_q == DONE) ? 1'b0 : (state_q == RDOUT) ? rdata_q[0] : 1'b1;
`else
    logic unused_data;
    assign unused_data = ^i_data;
    assign o_spi_miso  = (state_q != DONE);
`endif
    assign o_req        = req_q;
    assign o_we         = we_q;
    assign o_addr       = addr_q;
    assign o_data       = data_q;
    assign o_busy       = (state_q != IDLE);
    assign o_err_sticky = err_q;
endmodule
